// File: rtl/sim_step_scheduler.sv
// Frame-level sequencer for the rope node chain: one Verlet strobe per frame,
// then ITERS relaxation passes over the NUM_NODES-1 links through a shared
// constraint solver, with a per-link watchdog and overrun reporting.
module sim_step_scheduler #(
  parameter int NUM_NODES = 4,
  parameter int ITERS     = 2,
  parameter int PIN_NODE0 = 1,
  parameter int TIMEOUT   = 255,
  parameter int LINK_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 solve_done,
  output logic                 verlet_state,
  output logic                 solve_req,
  output logic [LINK_W-1:0]    link_idx,
  output logic [NUM_NODES-1:0] fix_en,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERLET    = 3'd1,
    SOLVE     = 3'd2,
    WRITEBACK = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                 state;
  logic [ITER_W-1:0]      iter;
  logic [WD_W-1:0]        wd;
  logic [NUM_NODES-1:0]   wb_mask;
  logic                   last_link;
  logic                   last_iter;
  logic                   wd_expired;

  // Node strobe pattern for the current link: nodes link_idx and link_idx+1,
  // with the anchored node 0 left untouched when pinned.
  generate
    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_mask
      if (gi == 0) begin : g_first
        assign wb_mask[gi] = (PIN_NODE0 == 0) && (link_idx == '0);
      end else begin : g_rest
        assign wb_mask[gi] = (link_idx == LINK_W'(gi)) || (link_idx == LINK_W'(gi - 1));
      end
    end
  endgenerate

  assign last_link  = (link_idx == LINK_W'(NUM_NODES - 2));
  assign last_iter  = (iter == ITER_W'(ITERS - 1));
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      iter         <= '0;
      wd           <= '0;
      link_idx     <= '0;
      verlet_state <= 1'b0;
      solve_req    <= 1'b0;
      fix_en       <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // single-cycle strobes default low
      verlet_state <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      fix_en       <= '0;

      // a tick that arrives outside IDLE is dropped but reported
      if (frame_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_tick) begin
            state        <= VERLET;
            verlet_state <= 1'b1;
            busy         <= 1'b1;
            link_idx     <= '0;
            iter         <= '0;
          end
        end

        VERLET: begin
          state     <= SOLVE;
          solve_req <= 1'b1;
          wd        <= '0;
        end

        SOLVE: begin
          if (solve_done) begin
            state     <= WRITEBACK;
            solve_req <= 1'b0;
            fix_en    <= wb_mask;
          end else if (wd_expired) begin
            // solver never answered: abandon the frame without frame_done
            state       <= IDLE;
            solve_req   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            link_idx    <= '0;
            iter        <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end

        WRITEBACK: begin
          wd <= '0;
          if (!last_link) begin
            link_idx  <= link_idx + LINK_W'(1);
            solve_req <= 1'b1;
            state     <= SOLVE;
          end else begin
            link_idx <= '0;
            if (!last_iter) begin
              iter      <= iter + ITER_W'(1);
              solve_req <= 1'b1;
              state     <= SOLVE;
            end else begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          solve_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Randomized scoreboard bench for sim_step_scheduler. Two instances share the
// same stimulus: one with node 0 pinned, one unpinned.
module tb_sim_step_scheduler;

  localparam int N  = 4;
  localparam int IT = 2;
  localparam int TO = 255;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic resp_done = 1'b0;
  logic stray_done = 1'b0;
  logic solve_done;
  assign solve_done = resp_done | stray_done;

  logic          a_verlet, a_req, a_busy, a_done, a_ovr, a_terr;
  logic [LW-1:0] a_link;
  logic [N-1:0]  a_fix;
  logic          b_verlet, b_req, b_busy, b_done, b_ovr, b_terr;
  logic [LW-1:0] b_link;
  logic [N-1:0]  b_fix;

  sim_step_scheduler #(.NUM_NODES(N), .ITERS(IT), .PIN_NODE0(1), .TIMEOUT(TO), .LINK_W(LW)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .solve_done(solve_done),
    .verlet_state(a_verlet), .solve_req(a_req), .link_idx(a_link), .fix_en(a_fix),
    .busy(a_busy), .frame_done(a_done), .overrun(a_ovr), .timeout_err(a_terr));

  sim_step_scheduler #(.NUM_NODES(N), .ITERS(IT), .PIN_NODE0(0), .TIMEOUT(TO), .LINK_W(LW)) dut_np (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .solve_done(solve_done),
    .verlet_state(b_verlet), .solve_req(b_req), .link_idx(b_link), .fix_en(b_fix),
    .busy(b_busy), .frame_done(b_done), .overrun(b_ovr), .timeout_err(b_terr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // solver behaviour for the current frame
  int lat = 0;
  bit stall = 1'b0;

  typedef struct packed {
    logic [N-1:0] pin;
    logic [N-1:0] nopin;
  } wb_t;

  int  verlet_q[$];
  int  req_q[$];
  int  frame_q[$];
  int  ovr_q[$];
  int  to_q[$];
  wb_t wb_q[$];

  int   m_exp;
  wb_t  m_wb;
  logic prev_req = 1'b0;
  logic prev_terr = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    return verlet_q.size() + req_q.size() + frame_q.size() + ovr_q.size() + to_q.size() + wb_q.size();
  endfunction

  task automatic flush();
    verlet_q.delete(); req_q.delete(); frame_q.delete();
    ovr_q.delete(); to_q.delete(); wb_q.delete();
  endtask

  // Solver model: acknowledges after lat extra cycles of solve_req, or never when stalled.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (a_req && !stall) begin
        resp_done = (wcnt >= lat);
        wcnt++;
      end else begin
        resp_done = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_verlet || b_verlet) begin
        if (verlet_q.size() == 0) chk("unexpected_verlet", 1, 0);
        else begin
          m_exp = verlet_q.pop_front();
          chk("verlet_cycle", cyc, m_exp);
          chk("verlet_both", {a_verlet, b_verlet}, 3);
        end
      end
      if (a_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_solve_req", 1, 0);
        else begin
          m_exp = req_q.pop_front();
          chk("req_link", a_link, m_exp);
          chk("req_link_np", {b_req, b_link}, {1'b1, LW'(m_exp)});
        end
      end
      if ((a_fix | b_fix) != '0) begin
        if (wb_q.size() == 0) chk("unexpected_fix_en", {a_fix, b_fix}, 0);
        else begin
          m_wb = wb_q.pop_front();
          chk("fix_en_pinned", a_fix, m_wb.pin);
          chk("fix_en_unpinned", b_fix, m_wb.nopin);
          chk("fix_with_verlet", {a_verlet, b_verlet}, 0);
        end
      end
      if (a_done || b_done) begin
        if (frame_q.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          m_exp = frame_q.pop_front();
          chk("frame_done_cycle", cyc, m_exp);
          chk("frame_done_both", {a_done, b_done}, 3);
        end
      end
      if (a_ovr || b_ovr) begin
        if (ovr_q.size() == 0) chk("unexpected_overrun", 1, 0);
        else begin
          m_exp = ovr_q.pop_front();
          chk("overrun_cycle", cyc, m_exp);
          chk("overrun_both", {a_ovr, b_ovr}, 3);
        end
      end
      if (a_terr && !prev_terr) begin
        if (to_q.size() == 0) chk("unexpected_timeout", 1, 0);
        else begin
          m_exp = to_q.pop_front();
          chk("timeout_cycle", cyc, m_exp);
          chk("timeout_req_low", {a_req, b_req}, 0);
          chk("timeout_busy_low", {a_busy, b_busy}, 0);
          chk("timeout_np", b_terr, 1);
        end
      end
    end
    prev_req  = a_req;
    prev_terr = a_terr;
  end

  // One frame: expectations are derived from the frame rules, then the
  // bench waits (bounded) until every expected event has been seen.
  task automatic run_frame(input int l, input bit st, input int ovr_k, input bit stray);
    int c;
    int j;
    logic [N-1:0] m;
    wb_t w;
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      stray_done = stray & ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    stray_done = 1'b0;
    lat = l;
    stall = st;
    c = cyc;
    frame_tick = 1'b1;
    verlet_q.push_back(c + 1);
    if (st) begin
      req_q.push_back(0);
      to_q.push_back(c + TO + 2);
    end else begin
      for (int it = 0; it < IT; it++) begin
        for (int lk = 0; lk < N - 1; lk++) begin
          req_q.push_back(lk);
          m = (N'(1) << lk) | (N'(1) << (lk + 1));
          w.nopin = m;
          w.pin = m & ~N'(1);
          wb_q.push_back(w);
        end
      end
      frame_q.push_back(c + 2 + IT * (N - 1) * (l + 2));
    end
    $display("[TB] frame tick cycle=%0d lat=%0d stall=%0d extra_tick=%0d stray=%0d", c, l, st, ovr_k, stray);
    j = 0;
    do begin
      @(negedge clk);
      j++;
      frame_tick = (j == ovr_k);
      if (j == ovr_k) ovr_q.push_back(cyc + 1);
      stray_done = stray && (j == 1);
    end while (!((j > ovr_k) && (j > 1) && (pending() == 0) && !a_busy) && (j < 2000));
    frame_tick = 1'b0;
    stray_done = 1'b0;
    if (j >= 2000) begin
      chk("frame_events_seen", pending(), 0);
      flush();
    end
  endtask

  // Reset asserted during the third SOLVE of a frame.
  task automatic reset_mid();
    int n;
    int j;
    logic pr;
    n = 0;
    j = 0;
    pr = 1'b0;
    @(negedge clk);
    lat = 4;
    stall = 1'b0;
    frame_tick = 1'b1;
    verlet_q.push_back(cyc + 1);
    for (int lk = 0; lk < 3; lk++) req_q.push_back(lk);
    for (int lk = 0; lk < 2; lk++) wb_q.push_back(wb_t'({N'((3 << lk) & ~1), N'(3 << lk)}));
    $display("[TB] frame tick cycle=%0d with reset in third solve", cyc);
    do begin
      @(negedge clk);
      frame_tick = 1'b0;
      j++;
      if (a_req && !pr) n++;
      pr = a_req;
    end while ((n < 3) && (j < 200));
    chk("third_solve_reached", n, 3);
    #1;
    reset = 1'b1;
    flush();
    @(negedge clk);
    chk("rst_busy", {a_busy, b_busy}, 0);
    chk("rst_solve_req", {a_req, b_req}, 0);
    chk("rst_fix_en", {a_fix, b_fix}, 0);
    chk("rst_link_idx", a_link, 0);
    chk("rst_timeout_err", {a_terr, b_terr}, 0);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a_verlet, a_req, a_link, a_fix, a_busy, a_done, a_ovr, a_terr}, 0);
    chk("reset_outputs_np", {b_verlet, b_req, b_link, b_fix, b_busy, b_done, b_ovr, b_terr}, 0);
    reset = 1'b0;

    run_frame(1, 1'b0, 0, 1'b1);   // solver acks one cycle late, stray acks ignored
    run_frame(0, 1'b0, 0, 1'b1);   // zero-wait solver, 14-cycle frame
    run_frame(0, 1'b0, 5, 1'b0);   // second tick 5 cycles in
    run_frame(0, 1'b1, 0, 1'b0);   // solver never answers
    run_frame(0, 1'b0, 0, 1'b0);   // next frame runs normally
    chk("timeout_err_sticky", {a_terr, b_terr}, 3);
    reset_mid();
    run_frame(0, 1'b0, 0, 1'b0);   // fresh frame after reset
    chk("timeout_err_cleared", {a_terr, b_terr}, 0);

    for (int k = 0; k < 12; k++) begin
      run_frame($urandom_range(0, 3),
                1'b0,
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : 0,
                ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", pending(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
